// File: rtl/expr_eval_fsm_pkg.sv
// Shared types, ASCII constants and character helpers for the expression evaluator.
package expr_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_NUM   = 2'd1,
        S_OP    = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] ch, input logic allow_minus);
        return (ch == CH_PLUS) || (ch == CH_STAR) || (allow_minus && (ch == CH_MINUS));
    endfunction

endpackage

// File: rtl/expr_eval_fsm_if.sv
// Character-stream input and evaluation-result bundle between a byte source and the evaluator.
interface expr_eval_fsm_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic [7:0]       in;
    logic             out;
    logic             err;
    logic             ovf;
    logic [WIDTH-1:0] result;

    modport master (
        output in_valid, in,
        input  out, err, ovf, result
    );

    modport slave (
        input  in_valid, in,
        output out, err, ovf, result
    );
endinterface

// File: rtl/expr_eval_fsm_char_class.sv
// Combinational classification of one ASCII character into the token classes the parser uses.
module expr_char_class
    import expr_pkg::*;
#(
    parameter int ALLOW_MINUS = 1,
    parameter int SKIP_SPACE  = 1
) (
    input  logic [7:0] ch_i,
    output logic       digit_o,
    output logic       plus_o,
    output logic       star_o,
    output logic       minus_o,
    output logic       op_o,
    output logic       space_o,
    output logic [3:0] val_o
);
    localparam logic MINUS_EN = (ALLOW_MINUS != 0);

    assign digit_o = is_digit(ch_i);
    assign plus_o  = (ch_i == CH_PLUS);
    assign star_o  = (ch_i == CH_STAR);
    assign minus_o = MINUS_EN && (ch_i == CH_MINUS);
    assign op_o    = is_op(ch_i, MINUS_EN);
    assign space_o = (SKIP_SPACE != 0) && (ch_i == CH_SPACE);
    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    assign val_o   = ch_i[3:0];
endmodule

// File: rtl/expr_eval_fsm.sv
// Streaming parser/evaluator for "number (op number)*" with '*' binding tighter than '+'/'-'.
module expr_eval_fsm
    import expr_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int MAX_DIGITS  = 4,
    parameter int ALLOW_MINUS = 1,
    parameter int SKIP_SPACE  = 1
) (
    input  logic            clk,
    input  logic            clr,
    expr_eval_fsm_if.slave  bus
);
    localparam int DCNT_W = $clog2(MAX_DIGITS + 1);

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    sum_q, sum_d;
    logic [WIDTH-1:0]    term_q, term_d;
    logic [WIDTH-1:0]    num_q, num_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                ovf_q, ovf_d;

    logic                c_digit, c_plus, c_star, c_minus, c_op, c_space;
    logic [3:0]          c_val;
    logic [WIDTH+3:0]    num_ext;
    logic [WIDTH-1:0]    prod;
    logic                take;

    expr_char_class #(
        .ALLOW_MINUS (ALLOW_MINUS),
        .SKIP_SPACE  (SKIP_SPACE)
    ) u_class (
        .ch_i    (bus.in),
        .digit_o (c_digit),
        .plus_o  (c_plus),
        .star_o  (c_star),
        .minus_o (c_minus),
        .op_o    (c_op),
        .space_o (c_space),
        .val_o   (c_val)
    );

    // Four spare bits hold num*10+9 exactly, so any carry out of WIDTH is an overflow.
    assign num_ext = ({4'b0, num_q} << 3) + ({4'b0, num_q} << 1) + {{WIDTH{1'b0}}, c_val};
    assign prod    = term_q * num_q;
    assign take    = bus.in_valid && !c_space;

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        term_d  = term_q;
        num_d   = num_q;
        dcnt_d  = dcnt_q;
        ovf_d   = ovf_q;

        if (take) begin
            unique case (state_q)
                S_START, S_OP: state_d = c_digit ? S_NUM : S_ERR;
                S_NUM: begin
                    if (c_digit)   state_d = (dcnt_q < DCNT_W'(MAX_DIGITS)) ? S_NUM : S_ERR;
                    else if (c_op) state_d = S_OP;
                    else           state_d = S_ERR;
                end
                default:           state_d = S_ERR;
            endcase
        end

        // The datapath freezes on any character that lands in, or is seen in, the error state.
        if (take && (state_q != S_ERR) && (state_d != S_ERR)) begin
            if (c_digit) begin
                num_d  = num_ext[WIDTH-1:0];
                dcnt_d = dcnt_q + DCNT_W'(1);
                if (|num_ext[WIDTH+3:WIDTH]) ovf_d = 1'b1;
            end else if (c_star) begin
                term_d = prod;
                num_d  = '0;
                dcnt_d = '0;
            end else if (c_plus || c_minus) begin
                sum_d  = sum_q + prod;
                term_d = c_minus ? '1 : WIDTH'(1);
                num_d  = '0;
                dcnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_START;
            sum_q   <= '0;
            term_q  <= WIDTH'(1);
            num_q   <= '0;
            dcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            term_q  <= term_d;
            num_q   <= num_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.out    = (state_q == S_NUM);
    assign bus.err    = (state_q == S_ERR);
    assign bus.ovf    = ovf_q;
    assign bus.result = sum_q + prod;
endmodule

// File: tb/tb_expr_eval_fsm.sv
// Drives one character stream into three differently-configured evaluators and checks each against a string-level model.
module tb_expr_eval_fsm;
    logic       clk = 1'b0;
    logic       tb_clr = 1'b1;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_in = 8'h00;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Configurations: 0 = defaults; 1 = 8-bit with '-'; 2 = 8-bit, no '-', spaces illegal, 3 digits.
    localparam int P_W   [3] = '{16, 8, 8};
    localparam int P_MAXD[3] = '{4, 4, 3};
    localparam int P_AM  [3] = '{1, 1, 0};
    localparam int P_SS  [3] = '{1, 1, 0};

    expr_eval_fsm_if #(.WIDTH(16)) if0 ();
    expr_eval_fsm_if #(.WIDTH(8))  if1 ();
    expr_eval_fsm_if #(.WIDTH(8))  if2 ();

    assign if0.in_valid = tb_valid;
    assign if0.in       = tb_in;
    assign if1.in_valid = tb_valid;
    assign if1.in       = tb_in;
    assign if2.in_valid = tb_valid;
    assign if2.in       = tb_in;

    expr_eval_fsm #(.WIDTH(16), .MAX_DIGITS(4), .ALLOW_MINUS(1), .SKIP_SPACE(1))
        dut0 (.clk(clk), .clr(tb_clr), .bus(if0));
    expr_eval_fsm #(.WIDTH(8), .MAX_DIGITS(4), .ALLOW_MINUS(1), .SKIP_SPACE(1))
        dut1 (.clk(clk), .clr(tb_clr), .bus(if1));
    expr_eval_fsm #(.WIDTH(8), .MAX_DIGITS(3), .ALLOW_MINUS(0), .SKIP_SPACE(0))
        dut2 (.clk(clk), .clr(tb_clr), .bus(if2));

    logic        obs_out[3];
    logic        obs_err[3];
    logic        obs_ovf[3];
    logic [15:0] obs_res[3];

    assign obs_out[0] = if0.out;
    assign obs_err[0] = if0.err;
    assign obs_ovf[0] = if0.ovf;
    assign obs_res[0] = if0.result;
    assign obs_out[1] = if1.out;
    assign obs_err[1] = if1.err;
    assign obs_ovf[1] = if1.ovf;
    assign obs_res[1] = {8'h00, if1.result};
    assign obs_out[2] = if2.out;
    assign obs_err[2] = if2.err;
    assign obs_ovf[2] = if2.ovf;
    assign obs_res[2] = {8'h00, if2.result};

    // Model: the accepted text itself, plus the grammar-level facts derived from it.
    string  m_txt[3];
    bit     m_err[3];
    bit     m_ovf[3];
    longint m_cur[3];
    int     m_dig[3];
    bit     m_fresh[3];

    function automatic longint eval_expr(input string s, input int w);
        longint mask;
        longint nums[$];
        byte    ops[$];
        longint cur;
        longint acc;
        longint t;
        byte    ch;
        mask = (longint'(1) << w) - 1;
        cur  = 0;
        for (int i = 0; i < s.len(); i++) begin
            ch = s[i];
            if (ch >= 8'h30 && ch <= 8'h39) begin
                cur = cur * 10 + longint'(ch - 8'h30);
            end else begin
                nums.push_back(cur);
                ops.push_back(ch);
                cur = 0;
            end
        end
        nums.push_back(cur);
        acc = 0;
        t   = nums[0];
        for (int i = 0; i < ops.size(); i++) begin
            if (ops[i] == 8'h2A) begin
                t = (t * nums[i+1]) & mask;
            end else begin
                acc = acc + t;
                t = (ops[i] == 8'h2B) ? nums[i+1] : -nums[i+1];
            end
        end
        return (acc + t) & mask;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_txt[k]   = "";
            m_err[k]   = 1'b0;
            m_ovf[k]   = 1'b0;
            m_cur[k]   = 0;
            m_dig[k]   = 0;
            m_fresh[k] = 1'b1;
        end
    endtask

    task automatic model_char(input byte c);
        bit is_dig, is_op;
        for (int k = 0; k < 3; k++) begin
            is_dig = (c >= 8'h30 && c <= 8'h39);
            is_op  = (c == 8'h2B) || (c == 8'h2A) || (c == 8'h2D && P_AM[k] != 0);
            if (m_err[k]) begin
            end else if (c == 8'h20 && P_SS[k] != 0) begin
            end else if (is_dig) begin
                if (m_dig[k] == P_MAXD[k]) begin
                    m_err[k] = 1'b1;
                end else begin
                    m_cur[k] = m_cur[k] * 10 + longint'(c - 8'h30);
                    m_dig[k]++;
                    if (m_cur[k] > (longint'(1) << P_W[k]) - 1) m_ovf[k] = 1'b1;
                    m_txt[k]   = $sformatf("%s%c", m_txt[k], c);
                    m_fresh[k] = 1'b0;
                end
            end else if (is_op && m_dig[k] > 0) begin
                m_cur[k]   = 0;
                m_dig[k]   = 0;
                m_txt[k]   = $sformatf("%s%c", m_txt[k], c);
                m_fresh[k] = 1'b0;
            end else begin
                m_err[k] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        bit          e_out;
        logic [15:0] e_res;
        for (int k = 0; k < 3; k++) begin
            e_out = !m_err[k] && (m_dig[k] > 0);
            checks++;
            assert (obs_out[k] === e_out) else begin
                errors++;
                $error("FAIL %s dut%0d out: got %0b want %0b", tag, k, obs_out[k], e_out);
            end
            checks++;
            assert (obs_err[k] === m_err[k]) else begin
                errors++;
                $error("FAIL %s dut%0d err: got %0b want %0b", tag, k, obs_err[k], m_err[k]);
            end
            checks++;
            assert (obs_ovf[k] === m_ovf[k]) else begin
                errors++;
                $error("FAIL %s dut%0d ovf: got %0b want %0b", tag, k, obs_ovf[k], m_ovf[k]);
            end
            if (e_out || m_fresh[k]) begin
                e_res = m_fresh[k] ? 16'h0 : 16'(eval_expr(m_txt[k], P_W[k]));
                checks++;
                assert (obs_res[k] === e_res) else begin
                    errors++;
                    $error("FAIL %s dut%0d result: got %0h want %0h", tag, k, obs_res[k], e_res);
                end
            end
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] got, input logic [15:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic step(input bit c, input bit v, input byte ch, input string tag);
        @(negedge clk);
        tb_clr   = c;
        tb_valid = v;
        tb_in    = ch;
        @(posedge clk);
        #1;
        if (c) model_reset();
        else if (v) model_char(ch);
        check_all(tag);
    endtask

    task automatic send_str(input string s, input string tag);
        for (int i = 0; i < s.len(); i++) step(1'b0, 1'b1, s[i], tag);
    endtask

    task automatic gap(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom_range(0, 255)), tag);
    endtask

    initial begin
        string alpha;
        int    r;
        model_reset();
        step(1'b1, 1'b0, 8'h00, "reset");
        step(1'b1, 1'b1, 8'h31, "reset_prio");

        send_str("12+3*4", "prec");
        check_const("prec_result", obs_res[0], 16'd24);

        step(1'b1, 1'b0, 8'h00, "clr");
        send_str("2-5", "minus");
        check_const("minus_wrap8", obs_res[1], 16'h00FD);
        check_const("minus_disabled_err", {15'h0, obs_err[2]}, 16'h1);

        step(1'b1, 1'b0, 8'h00, "clr");
        send_str("1++2", "dblop");
        step(1'b1, 1'b0, 8'h00, "clr");
        send_str("+1", "leadop");
        step(1'b1, 1'b0, 8'h00, "clr");
        send_str("12345", "maxdig");

        step(1'b1, 1'b0, 8'h00, "clr");
        send_str("300", "ovf");
        check_const("ovf_result8", obs_res[1], 16'd44);
        send_str("+1", "ovf_cont");
        check_const("ovf_cont8", obs_res[1], 16'd45);
        check_const("ovf_sticky", {15'h0, obs_ovf[1]}, 16'h1);

        step(1'b1, 1'b0, 8'h00, "clr");
        alpha = "7 * 6";
        for (int i = 0; i < alpha.len(); i++) begin
            step(1'b0, 1'b1, alpha[i], "space");
            gap(3, "gap");
        end
        check_const("space_result", obs_res[0], 16'd42);

        step(1'b1, 1'b0, 8'h00, "clr");
        send_str("9*", "midclr");
        step(1'b1, 1'b0, 8'h00, "midclr_clr");
        send_str("5", "midclr_after");
        check_const("midclr_result", obs_res[0], 16'd5);
        send_str("x", "toerr");
        step(1'b1, 1'b1, 8'h31, "errclr");
        check_const("errclr_err", {15'h0, obs_err[0]}, 16'h0);
        send_str("0007*3", "leadzero");
        check_const("leadzero", obs_res[0], 16'd21);

        alpha = "0123456789012345+*- +*x";
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)       step(1'b1, 1'($urandom_range(0, 1)), 8'h31, "rnd_clr");
            else if (r < 15) step(1'b0, 1'b0, alpha[$urandom_range(0, alpha.len() - 1)], "rnd_idle");
            else             step(1'b0, 1'b1, alpha[$urandom_range(0, alpha.len() - 1)], "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
